sr_pattern_driver: RTL and testbench

Sequential driver for the SR flip-flop. It accepts a WIDTH-bit target pattern over a valid/ready handshake and replays it MSB-first onto the flip-flop's s/r inputs, two cycles per bit. For each bit it emits the minimal SR excitation (set, reset or hold) against an internal model of q, never driving s and r high together. It reads back the flip-flop's q after every bit and flags any mismatch. It sits between pattern-producing control logic and one SR flip-flop instance sharing the same clock.

---
 rtl/sr_drv_pkg.sv | 25 ++
 rtl/sr_excite_calc.sv | 14 +
 rtl/sr_pattern_driver.sv | 129 ++++++++++++
 tb/tb_sr_pattern_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR flip-flop pattern driver.
// Holds the FSM state encoding and the minimal SR excitation function.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        StInit,
        StClear,
        StIdle,
        StDrive,
        StCheck
    } state_e;

    // {s, r} command encodings; s=r=1 is never produced.
    localparam logic [1:0] SrHold = 2'b00;
    localparam logic [1:0] SrSet  = 2'b10;
    localparam logic [1:0] SrRst  = 2'b01;

    function automatic logic [1:0] excite(input logic t, input logic m);
        if (t == m) begin
            return SrHold;
        end
        return t ? SrSet : SrRst;
    endfunction

endpackage

// File: rtl/sr_excite_calc.sv
// Combinational SR excitation: target bit t against modelled q m.
// Kept as its own block so the rule can be exercised in isolation.
module sr_excite_calc
    import sr_drv_pkg::*;
(
    input  logic t_i,
    input  logic m_i,
    output logic s_o,
    output logic r_o
);

    assign {s_o, r_o} = excite(t_i, m_i);

endmodule

// File: rtl/sr_pattern_driver.sv
// Replays a latched pattern MSB-first onto an SR flip-flop, two cycles per bit,
// checking the fed-back q after each bit and flagging any disagreement.
module sr_pattern_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch
);

    localparam int unsigned IdxW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              qm_q, qm_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic              done_q, done_d;
    logic              mism_q, mism_d;

    logic [IdxW-1:0]   idx_dec;
    logic              cur_bit;
    logic              exc_t;
    logic              exc_s;
    logic              exc_r;

    assign idx_dec = idx_q - IdxW'(1);
    assign cur_bit = data_q[idx_q];
    // In IDLE the first bit comes straight from the port; otherwise the next lower bit.
    assign exc_t   = (state_q == StIdle) ? load_data[WIDTH-1] : data_q[idx_dec];

    sr_excite_calc u_excite (
        .t_i (exc_t),
        .m_i (qm_q),
        .s_o (exc_s),
        .r_o (exc_r)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
            data_q  <= '0;
            idx_q   <= '0;
            qm_q    <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            qm_q    <= qm_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            mism_q  <= mism_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        qm_d    = qm_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        mism_d  = mism_q;
        unique case (state_q)
            StInit: begin
                r_d     = 1'b1;
                state_d = StClear;
            end
            StClear: begin
                qm_d    = 1'b0;
                state_d = StIdle;
            end
            StIdle: begin
                if (load_valid) begin
                    data_d     = load_data;
                    mism_d     = 1'b0;
                    idx_d      = IdxW'(WIDTH - 1);
                    {s_d, r_d} = {exc_s, exc_r};
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                qm_d    = cur_bit;
                state_d = StCheck;
            end
            StCheck: begin
                if (q_fb != cur_bit) begin
                    mism_d = 1'b1;
                end
                if (idx_q != '0) begin
                    idx_d      = idx_dec;
                    {s_d, r_d} = {exc_s, exc_r};
                    state_d    = StDrive;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        load_ready = (state_q == StIdle);
        busy       = (state_q == StDrive) || (state_q == StCheck);
        s          = s_q;
        r          = r_q;
        done       = done_q;
        mismatch   = mism_q;
    end

endmodule

// File: tb/tb_sr_pattern_driver.sv
// Self-checking bench: behavioural SR flip-flop on the feedback path,
// excitation table vectors, pattern table vectors and a mid-transfer reset.
module tb_sr_pattern_driver;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready;
    logic         s, r, busy, done, mismatch;
    logic         q_fb;
    logic         flop_q = 1'b1;
    logic         inj_en = 1'b0;
    logic         model_q = 1'b0;

    logic         et = 1'b0, em = 1'b0;
    logic         es, er;

    int           checks = 0;
    int           errors = 0;
    logic [1:0]   sb_q[$];

    always #5 clock = ~clock;

    // Real SR flip-flop behaviour, deliberately not starting at 0.
    always @(posedge clock) begin
        if (s) flop_q <= 1'b1;
        else if (r) flop_q <= 1'b0;
    end
    assign q_fb = flop_q ^ inj_en;

    sr_pattern_driver #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .s          (s),
        .r          (r),
        .q_fb       (q_fb),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch)
    );

    sr_excite_calc u_exc (
        .t_i (et),
        .m_i (em),
        .s_o (es),
        .r_o (er)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sr(input logic t, input logic m);
        if (t == m) return 2'b00;
        return t ? 2'b10 : 2'b01;
    endfunction

    always @(negedge clock) begin
        if (reset) chk("s_r_exclusive", {31'd0, s & r}, 32'd0);
    end

    // Assumes the call starts at a negedge; returns at the negedge of the done cycle.
    task automatic run_xfer(input logic [W-1:0] pat, input int inj_k, input bit hold_valid,
                            input logic exp_mm, input logic exp_q);
        int         n;
        logic [1:0] exp;
        logic       mm;
        n = 0;
        while (!load_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_load", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = pat;
        for (int k = 0; k < W; k++) begin
            sb_q.push_back(exp_sr(pat[W-1-k], model_q));
            model_q = pat[W-1-k];
        end
        @(negedge clock);
        if (!hold_valid) load_valid = 1'b0;
        load_data = ~pat;
        mm = 1'b0;
        for (int k = 0; k < W; k++) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 2'b11;
            chk("drive_sr", {30'd0, s, r}, {30'd0, exp});
            chk("drive_busy", {31'd0, busy}, 32'd1);
            chk("drive_done", {31'd0, done}, 32'd0);
            chk("drive_mismatch", {31'd0, mismatch}, {31'd0, mm});
            @(negedge clock);
            chk("check_sr", {30'd0, s, r}, 32'd0);
            chk("check_ready", {31'd0, load_ready}, 32'd0);
            inj_en = (k == inj_k);
            @(negedge clock);
            inj_en = 1'b0;
            if (k == inj_k) mm = 1'b1;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_ready", {31'd0, load_ready}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("final_mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
        chk("final_flop_q", {31'd0, flop_q}, {31'd0, exp_q});
    endtask

    typedef struct {
        logic t;
        logic m;
        logic [1:0] sr;
    } exc_vec_t;

    typedef struct {
        logic [W-1:0] pat;
        int           inj_k;
        bit           hold;
        logic         exp_mm;
        logic         exp_q;
    } xfer_vec_t;

    initial begin
        exc_vec_t  ev[4];
        xfer_vec_t xv[6];

        ev[0] = '{t: 1'b0, m: 1'b0, sr: 2'b00};
        ev[1] = '{t: 1'b0, m: 1'b1, sr: 2'b01};
        ev[2] = '{t: 1'b1, m: 1'b0, sr: 2'b10};
        ev[3] = '{t: 1'b1, m: 1'b1, sr: 2'b00};

        // inj_k counts from the MSB; k=2 is data bit 5.
        xv[0] = '{pat: 8'hA5, inj_k: -1, hold: 1'b0, exp_mm: 1'b0, exp_q: 1'b1};
        xv[1] = '{pat: 8'hFF, inj_k: -1, hold: 1'b1, exp_mm: 1'b0, exp_q: 1'b1};
        xv[2] = '{pat: 8'hFF, inj_k: -1, hold: 1'b0, exp_mm: 1'b0, exp_q: 1'b1};
        xv[3] = '{pat: 8'h80, inj_k: 2,  hold: 1'b1, exp_mm: 1'b1, exp_q: 1'b0};
        xv[4] = '{pat: 8'h3C, inj_k: -1, hold: 1'b1, exp_mm: 1'b0, exp_q: 1'b0};
        xv[5] = '{pat: 8'h00, inj_k: -1, hold: 1'b0, exp_mm: 1'b0, exp_q: 1'b0};

        for (int i = 0; i < 4; i++) begin
            et = ev[i].t;
            em = ev[i].m;
            #1;
            chk("excite_calc", {30'd0, es, er}, {30'd0, ev[i].sr});
        end

        repeat (3) @(negedge clock);
        chk("rst_s", {31'd0, s}, 32'd0);
        chk("rst_r", {31'd0, r}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
        reset = 1'b1;
        chk("init_r", {31'd0, r}, 32'd0);
        @(negedge clock);
        chk("clear_r", {31'd0, r}, 32'd1);
        chk("clear_s", {31'd0, s}, 32'd0);
        chk("clear_ready", {31'd0, load_ready}, 32'd0);
        @(negedge clock);
        chk("idle_r", {31'd0, r}, 32'd0);
        chk("idle_ready", {31'd0, load_ready}, 32'd1);
        chk("idle_flop_q", {31'd0, flop_q}, 32'd0);
        @(negedge clock);
        chk("idle_ready_hold", {31'd0, load_ready}, 32'd1);
        chk("idle_s", {31'd0, s}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_xfer(xv[i].pat, xv[i].inj_k, xv[i].hold, xv[i].exp_mm, xv[i].exp_q);
        end
        load_valid = 1'b0;
        @(negedge clock);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // Reset during the third DRIVE cycle of 8'hA5 (that bit is a set).
        load_valid = 1'b1;
        load_data  = 8'hA5;
        @(negedge clock);
        load_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_pre_s", {30'd0, s, r}, 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_sr", {30'd0, s, r}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        #1;
        reset   = 1'b1;
        model_q = 1'b0;
        @(negedge clock);
        chk("rerun_clear_r", {31'd0, r}, 32'd1);
        chk("rerun_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        chk("rerun_ready", {31'd0, load_ready}, 32'd1);
        chk("rerun_done2", {31'd0, done}, 32'd0);
        run_xfer(8'h01, -1, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
